rps_match_scorer: RTL and testbench

- Downstream of the stone-paper-scissors round evaluator; consumes one 2-bit round-result code per round and keeps match state.
- Tracks the following per match:
  - per-player scores
  - the number of played rounds
  - tie and invalid counts
  - the current win streak
- Declares a match winner at WIN_TARGET wins, or declares a draw/decision at MAX_ROUNDS.
- Outputs feed the top-level display mux.

---
 rtl/rps_pkg.sv | 21 ++
 rtl/rps_sat_counter.sv | 26 ++
 rtl/rps_match_scorer.sv | 175 +++++++++++++++++
 tb/tb_rps_match_scorer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared codes for the stone-paper-scissors match scorer.
// Round-result codes, winner codes and scorer FSM states.
package rps_pkg;

    typedef enum logic [1:0] {
        RES_TIE     = 2'b00,
        RES_P1      = 2'b01,
        RES_P2      = 2'b10,
        RES_INVALID = 2'b11
    } res_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic {
        S_PLAY = 1'b0,
        S_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/rps_sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr and inc together restart the count at one.
module rps_sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    // Count register: clear/restart, else increment until full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && cnt != CMAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rps_match_scorer.sv
// Match scorer: keeps scores, round/tie/invalid counts and streak,
// and declares a winner or a decision at the round limit.
module rps_match_scorer
    import rps_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             round_valid,
    input  logic [1:0]       round_result,
    input  logic             clear,
    output logic [CNT_W-1:0] p1_score,
    output logic [CNT_W-1:0] p2_score,
    output logic [CNT_W-1:0] round_count,
    output logic [CNT_W-1:0] tie_count,
    output logic [CNT_W-1:0] invalid_count,
    output logic [CNT_W-1:0] streak,
    output logic [1:0]       streak_owner,
    output logic             score_evt,
    output logic             match_done,
    output logic [1:0]       match_winner
);

    localparam logic [CNT_W-1:0] WT = CNT_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0] MR = CNT_W'(MAX_ROUNDS);

    state_t state;
    state_t state_nxt;

    logic acc;
    logic is_p1;
    logic is_p2;
    logic is_tie;
    logic is_inv;
    logic played;
    logic stk_clr;
    logic finish;

    logic [CNT_W-1:0] p1_nxt;
    logic [CNT_W-1:0] p2_nxt;
    logic [CNT_W-1:0] rc_nxt;

    logic       evt_d;
    logic       done_d;
    logic [1:0] win_d;
    logic [1:0] own_d;

    // Rounds are only taken while playing and not being cleared.
    assign acc = round_valid && (state == S_PLAY) && !clear;

    // Decode the accepted round into one-hot events.
    always_comb begin
        is_p1  = 1'b0;
        is_p2  = 1'b0;
        is_tie = 1'b0;
        is_inv = 1'b0;
        unique case (round_result)
            RES_TIE: is_tie = acc;
            RES_P1:  is_p1  = acc;
            RES_P2:  is_p2  = acc;
            default: is_inv = acc;
        endcase
    end

    assign played = is_p1 | is_p2 | is_tie;

    // Streak restarts on a tie or when the other player wins.
    assign stk_clr = clear | is_tie
                   | (is_p1 && streak_owner != WIN_P1)
                   | (is_p2 && streak_owner != WIN_P2);

    rps_sat_counter #(.CNT_W(CNT_W)) u_p1 (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(is_p1), .cnt(p1_score)
    );

    rps_sat_counter #(.CNT_W(CNT_W)) u_p2 (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(is_p2), .cnt(p2_score)
    );

    rps_sat_counter #(.CNT_W(CNT_W)) u_rc (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(played), .cnt(round_count)
    );

    rps_sat_counter #(.CNT_W(CNT_W)) u_tie (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(is_tie), .cnt(tie_count)
    );

    rps_sat_counter #(.CNT_W(CNT_W)) u_inv (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(is_inv), .cnt(invalid_count)
    );

    rps_sat_counter #(.CNT_W(CNT_W)) u_stk (
        .clk(clk), .rst_n(rst_n), .clr(stk_clr), .inc(is_p1 | is_p2), .cnt(streak)
    );

    // Post-update values used for the end-of-match decision.
    assign p1_nxt = p1_score + CNT_W'(is_p1);
    assign p2_nxt = p2_score + CNT_W'(is_p2);
    assign rc_nxt = round_count + CNT_W'(played);

    assign finish = played && (p1_nxt == WT || p2_nxt == WT || rc_nxt == MR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_PLAY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: clear restarts, a finishing round ends the match.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_PLAY;
        end else if (finish) begin
            state_nxt = S_DONE;
        end
    end

    // Next values of the registered flags, winner and streak owner.
    always_comb begin
        evt_d  = played;
        done_d = match_done;
        win_d  = match_winner;
        own_d  = streak_owner;
        if (clear) begin
            done_d = 1'b0;
            win_d  = WIN_NONE;
            own_d  = WIN_NONE;
        end else begin
            if (is_tie) begin
                own_d = WIN_NONE;
            end else if (is_p1) begin
                own_d = WIN_P1;
            end else if (is_p2) begin
                own_d = WIN_P2;
            end
            if (finish) begin
                done_d = 1'b1;
                if (p1_nxt == WT) begin
                    win_d = WIN_P1;
                end else if (p2_nxt == WT) begin
                    win_d = WIN_P2;
                end else if (p1_nxt > p2_nxt) begin
                    win_d = WIN_P1;
                end else if (p2_nxt > p1_nxt) begin
                    win_d = WIN_P2;
                end else begin
                    win_d = WIN_NONE;
                end
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_evt    <= 1'b0;
            match_done   <= 1'b0;
            match_winner <= WIN_NONE;
            streak_owner <= WIN_NONE;
        end else begin
            score_evt    <= evt_d;
            match_done   <= done_d;
            match_winner <= win_d;
            streak_owner <= own_d;
        end
    end

endmodule

// File: tb/tb_rps_match_scorer.sv
// Self-checking bench for rps_match_scorer.
// Table of per-cycle stimulus and expected outputs, plus corner sequences.
module tb_rps_match_scorer;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             round_valid;
    logic [1:0]       round_result;
    logic             clear;
    logic [CNT_W-1:0] p1_score;
    logic [CNT_W-1:0] p2_score;
    logic [CNT_W-1:0] round_count;
    logic [CNT_W-1:0] tie_count;
    logic [CNT_W-1:0] invalid_count;
    logic [CNT_W-1:0] streak;
    logic [1:0]       streak_owner;
    logic             score_evt;
    logic             match_done;
    logic [1:0]       match_winner;

    int tests = 0;
    int fails = 0;

    rps_match_scorer #(
        .CNT_W(CNT_W), .WIN_TARGET(3), .MAX_ROUNDS(9)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .round_valid(round_valid), .round_result(round_result),
        .clear(clear),
        .p1_score(p1_score), .p2_score(p2_score),
        .round_count(round_count), .tie_count(tie_count),
        .invalid_count(invalid_count), .streak(streak),
        .streak_owner(streak_owner), .score_evt(score_evt),
        .match_done(match_done), .match_winner(match_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         clr;
        bit         v;
        logic [1:0] res;
        int p1, p2, rc, tie, inv, stk, own, evt, done, win;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic add(input bit c, input bit v, input int r,
                       input int p1, input int p2, input int rc,
                       input int tie, input int inv, input int stk,
                       input int own, input int evt, input int done,
                       input int win);
        vec_t e;
        e.clr = c; e.v = v; e.res = 2'(r);
        e.p1 = p1; e.p2 = p2; e.rc = rc; e.tie = tie; e.inv = inv;
        e.stk = stk; e.own = own; e.evt = evt; e.done = done; e.win = win;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, " p1_score"}, int'(p1_score), e.p1);
        chk({tag, " p2_score"}, int'(p2_score), e.p2);
        chk({tag, " round_count"}, int'(round_count), e.rc);
        chk({tag, " tie_count"}, int'(tie_count), e.tie);
        chk({tag, " invalid_count"}, int'(invalid_count), e.inv);
        chk({tag, " streak"}, int'(streak), e.stk);
        chk({tag, " streak_owner"}, int'(streak_owner), e.own);
        chk({tag, " score_evt"}, int'(score_evt), e.evt);
        chk({tag, " match_done"}, int'(match_done), e.done);
        chk({tag, " match_winner"}, int'(match_winner), e.win);
    endtask

    task automatic drive(input bit c, input bit v, input logic [1:0] r);
        @(negedge clk);
        clear        = c;
        round_valid  = v;
        round_result = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t z;
        vec_t e;
        z = '{clr: 1'b0, v: 1'b0, res: 2'b00, default: 0};

        // 3x P1 -> match win at third edge
        add(0,1,1, 1,0,1,0,0,1,1,1,0,0);
        add(0,1,1, 2,0,2,0,0,2,1,1,0,0);
        add(0,1,1, 3,0,3,0,0,3,1,1,1,1);
        add(0,0,0, 3,0,3,0,0,3,1,0,1,1);
        // Round-limit draw
        add(1,0,0, 0,0,0,0,0,0,0,0,0,0);
        add(0,1,1, 1,0,1,0,0,1,1,1,0,0);
        add(0,1,2, 1,1,2,0,0,1,2,1,0,0);
        add(0,1,0, 1,1,3,1,0,0,0,1,0,0);
        add(0,1,0, 1,1,4,2,0,0,0,1,0,0);
        add(0,1,1, 2,1,5,2,0,1,1,1,0,0);
        add(0,1,2, 2,2,6,2,0,1,2,1,0,0);
        add(0,1,0, 2,2,7,3,0,0,0,1,0,0);
        add(0,1,0, 2,2,8,4,0,0,0,1,0,0);
        add(0,1,0, 2,2,9,5,0,0,0,1,1,0);
        // Invalids are not rounds
        add(1,0,0, 0,0,0,0,0,0,0,0,0,0);
        add(0,1,3, 0,0,0,0,1,0,0,0,0,0);
        add(0,1,3, 0,0,0,0,2,0,0,0,0,0);
        add(0,1,1, 1,0,1,0,2,1,1,1,0,0);
        add(0,0,0, 1,0,1,0,2,1,1,0,0,0);
        // P2 wins, then rounds ignored, clear, replay
        add(0,1,2, 1,1,2,0,2,1,2,1,0,0);
        add(0,1,2, 1,2,3,0,2,2,2,1,0,0);
        add(0,1,2, 1,3,4,0,2,3,2,1,1,2);
        add(0,1,1, 1,3,4,0,2,3,2,0,1,2);
        add(0,1,1, 1,3,4,0,2,3,2,0,1,2);
        add(1,0,0, 0,0,0,0,0,0,0,0,0,0);
        add(0,1,1, 1,0,1,0,0,1,1,1,0,0);
        // clear beats a simultaneous round
        add(0,1,2, 1,1,2,0,0,1,2,1,0,0);
        add(1,1,1, 0,0,0,0,0,0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0,0,0,0,0,0);
        // Streak handover
        add(0,1,1, 1,0,1,0,0,1,1,1,0,0);
        add(0,1,1, 2,0,2,0,0,2,1,1,0,0);
        add(0,1,2, 2,1,3,0,0,1,2,1,0,0);
        // Round-limit decision for the higher score
        add(1,0,0, 0,0,0,0,0,0,0,0,0,0);
        add(0,1,1, 1,0,1,0,0,1,1,1,0,0);
        add(0,1,2, 1,1,2,0,0,1,2,1,0,0);
        for (int k = 0; k < 6; k++)
            add(0,1,0, 1,1,3+k,1+k,0,0,0,1,0,0);
        add(0,1,1, 2,1,9,6,0,1,1,1,1,1);

        rst_n        = 1'b0;
        clear        = 1'b0;
        round_valid  = 1'b0;
        round_result = 2'b00;
        #12;
        chk_all("reset", z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            sb.push_back(tbl[i]);
            drive(tbl[i].clr, tbl[i].v, tbl[i].res);
            if (sb.size() == 0) begin
                chk("scoreboard empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk_all($sformatf("vec%0d", i), e);
            end
        end

        // Asynchronous reset between edges
        @(negedge clk);
        clear       = 1'b0;
        round_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", z);
        @(negedge clk);
        rst_n = 1'b1;

        // invalid_count saturates at 15
        for (int k = 0; k < 17; k++)
            drive(1'b0, 1'b1, 2'b11);
        e = z;
        e.inv = 15;
        chk_all("inv_sat", e);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
